// File: rtl/spi_packet_assembler.sv
// Assembles the SPI receive byte stream into interest/data packets and presents
// them to the FIB on a valid/ready handshake, all fields in parallel.
module spi_packet_assembler #(
  parameter int unsigned PREFIX_BYTES   = 8,
  parameter int unsigned DATA_BYTES     = 32,
  parameter int unsigned TYPE_BIT       = 7,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      RX_valid,
  input  logic [7:0]                data_SPI_in,
  input  logic                      pkt_ready,
  output logic                      pkt_valid,
  output logic                      pkt_is_data,
  output logic [7:0]                pkt_metadata,
  output logic [8*PREFIX_BYTES-1:0] pkt_prefix,
  output logic [8*DATA_BYTES-1:0]   pkt_data,
  output logic                      busy,
  output logic                      err_timeout,
  output logic                      err_overflow
);

  localparam int unsigned PREFIX_W = 8 * PREFIX_BYTES;
  localparam int unsigned DATA_W   = 8 * DATA_BYTES;
  localparam int unsigned BYTE_W   = 6;
  localparam int unsigned IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RX_PREFIX = 2'd1,
    RX_DATA   = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t              r_state;
  logic [BYTE_W-1:0]   r_byte_cnt;
  logic [IDLE_W-1:0]   r_idle_cnt;
  logic [7:0]          r_metadata;
  logic [PREFIX_W-1:0] r_prefix;
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic                r_busy;
  logic                r_err_timeout;
  logic                r_err_overflow;

  logic w_capture;
  logic w_timeout;

  // A metadata byte is taken in IDLE, or in HOLD on the same edge the packet is accepted.
  assign w_capture = RX_valid && ((r_state == IDLE) || ((r_state == HOLD) && pkt_ready));
  assign w_timeout = !RX_valid && (r_idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_byte_cnt     <= '0;
      r_idle_cnt     <= '0;
      r_metadata     <= '0;
      r_prefix       <= '0;
      r_data         <= '0;
      r_valid        <= 1'b0;
      r_busy         <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_err_timeout  <= 1'b0;
      r_err_overflow <= 1'b0;
      if (w_capture) begin
        r_metadata <= data_SPI_in;
        r_prefix   <= '0;
        r_data     <= '0;
        r_byte_cnt <= '0;
        r_idle_cnt <= '0;
        r_valid    <= 1'b0;
        r_busy     <= 1'b1;
        r_state    <= RX_PREFIX;
      end else begin
        case (r_state)
          RX_PREFIX, RX_DATA: begin
            if (RX_valid) begin
              r_idle_cnt <= '0;
              r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
              if (r_state == RX_PREFIX) begin
                r_prefix <= PREFIX_W'({r_prefix, data_SPI_in});
                if (r_byte_cnt == BYTE_W'(PREFIX_BYTES - 1)) begin
                  if (r_metadata[TYPE_BIT]) begin
                    r_byte_cnt <= '0;
                    r_state    <= RX_DATA;
                  end else begin
                    r_valid <= 1'b1;
                    r_state <= HOLD;
                  end
                end
              end else begin
                r_data <= DATA_W'({r_data, data_SPI_in});
                if (r_byte_cnt == BYTE_W'(DATA_BYTES - 1)) begin
                  r_valid <= 1'b1;
                  r_state <= HOLD;
                end
              end
            end else if (w_timeout) begin
              // Abort the partial packet; it is never presented.
              r_idle_cnt    <= '0;
              r_err_timeout <= 1'b1;
              r_busy        <= 1'b0;
              r_state       <= IDLE;
            end else begin
              r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end
          end
          HOLD: begin
            if (RX_valid && !pkt_ready) begin
              r_err_overflow <= 1'b1;
            end else if (pkt_ready) begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  assign pkt_valid    = r_valid;
  assign pkt_is_data  = r_metadata[TYPE_BIT];
  assign pkt_metadata = r_metadata;
  assign pkt_prefix   = r_prefix;
  assign pkt_data     = r_data;
  assign busy         = r_busy;
  assign err_timeout  = r_err_timeout;
  assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_spi_packet_assembler.sv
// Directed bench for spi_packet_assembler: interest, data, backpressure,
// overflow/back-to-back, timeout and mid-packet reset.
module tb_spi_packet_assembler;

  logic         clk;
  logic         rst;
  logic         RX_valid;
  logic [7:0]   data_SPI_in;
  logic         pkt_ready;
  logic         pkt_valid;
  logic         pkt_is_data;
  logic [7:0]   pkt_metadata;
  logic [63:0]  pkt_prefix;
  logic [255:0] pkt_data;
  logic         busy;
  logic         err_timeout;
  logic         err_overflow;

  int n_checks = 0;
  int n_errors = 0;

  spi_packet_assembler dut (
    .clk          (clk),
    .rst          (rst),
    .RX_valid     (RX_valid),
    .data_SPI_in  (data_SPI_in),
    .pkt_ready    (pkt_ready),
    .pkt_valid    (pkt_valid),
    .pkt_is_data  (pkt_is_data),
    .pkt_metadata (pkt_metadata),
    .pkt_prefix   (pkt_prefix),
    .pkt_data     (pkt_data),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte for one edge, then release the bus 1 ns after it.
  task automatic send(input logic [7:0] b);
    RX_valid    = 1'b1;
    data_SPI_in = b;
    @(posedge clk);
    #1;
    RX_valid    = 1'b0;
    data_SPI_in = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] std_bytes [9];

  task automatic send_std_interest();
    for (int i = 0; i < 9; i++) send(std_bytes[i]);
  endtask

  task automatic check_std_interest(input string tag);
    check({tag, "_valid"},  pkt_valid, 1);
    check({tag, "_isdata"}, pkt_is_data, 0);
    check({tag, "_meta"},   pkt_metadata, 8'h30);
    check({tag, "_prefix"}, pkt_prefix, 64'h0000FFFF0000FFFF);
    check({tag, "_data"},   pkt_data, 0);
  endtask

  logic [255:0] exp_data;
  int           n_pulse;
  int           n_early;
  int           n_vseen;

  initial begin
    std_bytes   = '{8'h30, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
    rst         = 1'b0;
    RX_valid    = 1'b0;
    data_SPI_in = 8'h00;
    pkt_ready   = 1'b0;
    repeat (3) tick();
    check("rst_valid", pkt_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fields", {pkt_metadata, pkt_prefix}, 0);
    rst = 1'b1;
    tick();

    // 1: interest, ready held high
    pkt_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(std_bytes[i]);
    check("t1_valid_before_last", pkt_valid, 0);
    check("t1_busy", busy, 1);
    send(std_bytes[8]);
    check_std_interest("t1");
    tick();
    check("t1_valid_one_cycle", pkt_valid, 0);
    check("t1_busy_after", busy, 0);

    // 2: data packet
    send(8'hB0);
    send(8'h01); send(8'h23); send(8'h45); send(8'h67);
    send(8'h89); send(8'hAB); send(8'hCD); send(8'hEF);
    exp_data = '0;
    for (int i = 0; i < 32; i++) begin
      check("t2_not_valid_early", pkt_valid, 0);
      send(8'(i));
      exp_data = {exp_data[247:0], 8'(i)};
    end
    check("t2_valid", pkt_valid, 1);
    check("t2_isdata", pkt_is_data, 1);
    check("t2_meta", pkt_metadata, 8'hB0);
    check("t2_prefix", pkt_prefix, 64'h0123456789ABCDEF);
    check("t2_data", pkt_data, exp_data);
    tick();
    check("t2_valid_drop", pkt_valid, 0);

    // 3: backpressure
    pkt_ready = 1'b0;
    send_std_interest();
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_valid", pkt_valid, 1);
      check("t3_hold_prefix", pkt_prefix, 64'h0000FFFF0000FFFF);
      tick();
    end
    check_std_interest("t3");
    pkt_ready = 1'b1;
    tick();
    check("t3_valid_drop", pkt_valid, 0);
    check("t3_busy", busy, 0);

    // 4: overflow then back-to-back capture
    pkt_ready = 1'b0;
    send(8'h01);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    check("t4_valid", pkt_valid, 1);
    check("t4_ovf_idle", err_overflow, 0);
    send(8'h55);
    check("t4_ovf_pulse", err_overflow, 1);
    check("t4_ovf_meta", pkt_metadata, 8'h01);
    check("t4_ovf_prefix", pkt_prefix, 64'h1122334455667788);
    check("t4_ovf_valid", pkt_valid, 1);
    tick();
    check("t4_ovf_clear", err_overflow, 0);
    pkt_ready = 1'b1;
    send(8'h30);
    check("t4_b2b_valid", pkt_valid, 0);
    check("t4_b2b_busy", busy, 1);
    check("t4_b2b_meta", pkt_metadata, 8'h30);
    check("t4_b2b_ovf", err_overflow, 0);
    for (int i = 1; i < 9; i++) send(std_bytes[i]);
    check_std_interest("t4");
    tick();
    check("t4_valid_drop", pkt_valid, 0);

    // 5: timeout after a partial interest
    send(8'h30); send(8'h01); send(8'h02); send(8'h03);
    n_pulse = 0;
    n_early = 0;
    n_vseen = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (err_timeout) begin
        n_pulse++;
        if (i < 63) n_early++;
      end
      if (pkt_valid) n_vseen++;
    end
    check("t5_pulse_count", n_pulse, 1);
    check("t5_pulse_early", n_early, 0);
    check("t5_no_valid", n_vseen, 0);
    check("t5_busy", busy, 0);
    send_std_interest();
    check_std_interest("t5");
    tick();
    check("t5_valid_drop", pkt_valid, 0);

    // 6: asynchronous reset mid data packet
    send(8'hB0);
    for (int i = 0; i < 19; i++) send(8'(8'hA0 + i));
    check("t6_busy_pre", busy, 1);
    #1;
    rst = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_meta", pkt_metadata, 0);
    check("t6_rst_prefix", pkt_prefix, 0);
    check("t6_rst_data", pkt_data, 0);
    check("t6_rst_flags", {pkt_valid, pkt_is_data, err_timeout, err_overflow}, 0);
    tick();
    rst = 1'b1;
    tick();
    send_std_interest();
    check_std_interest("t6");
    tick();
    check("t6_valid_drop", pkt_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
